// File: rtl/memory_access_stage_pkg.sv
// Shared encodings for the MEM stage: result-select codes and the
// data-memory handshake state codes.
package memory_access_stage_pkg;

    localparam int WORD_SIZE = 32;

    // ResultSrc encodings (11 is unused and selects zero)
    localparam logic [1:0] RESULT_ALU = 2'b00;
    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam logic [1:0] RESULT_PC4 = 2'b10;

    // Data-memory handshake states
    typedef enum logic [1:0] {
        MEMST_IDLE  = 2'b00,
        MEMST_BUSY  = 2'b01,
        MEMST_ABORT = 2'b10
    } memst_e;

endpackage

// File: rtl/memory_access_stage_handshake.sv
// dmem_handshake: req/ack sequencing for the data-memory port.
// Tracks how long a request has been waiting, raises a stall while the
// memory has not acknowledged, and forces a one-cycle abort once the
// request has waited TIMEOUT cycles without an ack.
//
// Handshake: dmem_req is asserted whenever an aligned memory op sits in M
// (and the stage is not aborting); a transfer completes in any cycle where
// req and ack are both high. ack with req low is ignored. While req is high
// and ack low the stage stalls, and upstream holds every M input stable.
module dmem_handshake
    import memory_access_stage_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CW      = 5
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   req_valid,
    input  logic   ack,
    output logic   req,
    output logic   stall,
    output logic   abort,
    output memst_e state
);

    logic [CW-1:0] wait_cnt;

    // Request is combinational so a zero-wait memory completes in one cycle;
    // rst gates it so an asynchronous reset drops the request at once.
    assign req   = req_valid & (state != MEMST_ABORT) & ~rst;
    assign stall = req & ~ack;
    assign abort = (state == MEMST_ABORT);

    // Handshake FSM with the timeout counter; an ack in the expiry cycle wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= MEMST_IDLE;
            wait_cnt <= '0;
        end else begin
            case (state)
                MEMST_IDLE: begin
                    if (req && !ack) begin
                        state    <= MEMST_BUSY;
                        wait_cnt <= CW'(1);
                    end
                end
                MEMST_BUSY: begin
                    if (!req || ack) begin
                        state    <= MEMST_IDLE;
                        wait_cnt <= '0;
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        state    <= MEMST_ABORT;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                MEMST_ABORT: begin
                    state    <= MEMST_IDLE;
                    wait_cnt <= '0;
                end
                default: begin
                    state    <= MEMST_IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/memory_access_stage.sv
// RISC-V MEM stage: drives the data-memory port for loads and stores,
// holds the M->W pipeline registers, produces ResultW for writeback and
// forwarding, and traps misaligned accesses and memory timeouts.
module memory_access_stage
    import memory_access_stage_pkg::*;
#(
    parameter int DW      = WORD_SIZE,
    parameter int TIMEOUT = 16,
    parameter int CW      = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] ALUResultM,
    input  logic [DW-1:0] WriteDataM,
    input  logic [DW-1:0] PCPlus4M,
    input  logic [4:0]    RdM,
    input  logic          RegWriteM,
    input  logic          MemWriteM,
    input  logic [1:0]    ResultSrcM,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic          dmem_ack,
    input  logic [DW-1:0] dmem_rdata,
    output logic          StallM,
    output logic [DW-1:0] ALUResultW,
    output logic [DW-1:0] ReadDataW,
    output logic [DW-1:0] PCPlus4W,
    output logic [4:0]    RdW,
    output logic          RegWriteW,
    output logic [1:0]    ResultSrcW,
    output logic [DW-1:0] ResultW,
    output logic          misaligned,
    output logic          bus_error,
    output memst_e        mem_state
);

    logic is_load;
    logic mem_op;
    logic aligned;
    logic abort;
    logic bubble;

    assign is_load = (ResultSrcM == RESULT_MEM);
    assign mem_op  = MemWriteM | is_load;
    assign aligned = (ALUResultM[1:0] == 2'b00);

    dmem_handshake #(
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) u_handshake (
        .clk       (clk),
        .rst       (rst),
        .req_valid (mem_op & aligned),
        .ack       (dmem_ack),
        .req       (dmem_req),
        .stall     (StallM),
        .abort     (abort),
        .state     (mem_state)
    );

    assign dmem_we    = MemWriteM;
    assign dmem_addr  = ALUResultM;
    assign dmem_wdata = WriteDataM;

    // A misaligned memory op never reaches the bus; it is flagged for one cycle.
    assign misaligned = mem_op & ~aligned & ~rst;

    // The M instruction does not retire while waiting, aborting or trapped.
    assign bubble = StallM | abort | misaligned;

    // M->W pipeline register; a bubble only clears RegWriteW.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ALUResultW <= '0;
            ReadDataW  <= '0;
            PCPlus4W   <= '0;
            RdW        <= '0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= RESULT_ALU;
        end else if (bubble) begin
            RegWriteW  <= 1'b0;
        end else begin
            ALUResultW <= ALUResultM;
            PCPlus4W   <= PCPlus4M;
            RdW        <= RdM;
            RegWriteW  <= RegWriteM;
            ResultSrcW <= ResultSrcM;
            if (is_load && dmem_req && dmem_ack) begin
                ReadDataW <= dmem_rdata;
            end
        end
    end

    // Sticky record that some request was abandoned after the timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_error <= 1'b0;
        end else if (abort) begin
            bus_error <= 1'b1;
        end
    end

    // Writeback result select (3-to-1; the unused code yields zero).
    always_comb begin
        ResultW = '0;
        case (ResultSrcW)
            RESULT_ALU: ResultW = ALUResultW;
            RESULT_MEM: ResultW = ReadDataW;
            RESULT_PC4: ResultW = PCPlus4W;
            default:    ResultW = '0;
        endcase
    end

endmodule
